// File: rtl/isa_shared_pkg.sv
// Shared load/store definitions: responder state encoding, request classes and
// the word size that sets the byte-offset width of data addresses.
package isa_shared;

  localparam int DMEM_WORD_BYTES = 4;

  typedef enum logic [1:0] {
    DM_IDLE,
    DM_WAIT,
    DM_RESP
  } dmem_state_t;

  typedef enum logic [1:0] {
    REQ_ERR,
    REQ_WRITE,
    REQ_READ
  } dmem_req_class_t;

endpackage

// File: rtl/dmem_array.sv
// Word-wide data store: writes commit on the clock edge, reads are combinational
// from the selected word so the responder can capture them into its response register.
module dmem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // NOTE: storage arrays carry no reset; clearing them would cost a write port per word.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder with fixed read latency and a registered
// valid/ready response. Optional DMEM_ALIGN_CHECK_EN rejects non-word-aligned addresses.
module dmem_responder
  import isa_shared::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 256,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_read,
  input  logic                  req_write,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DMEM_WORD_BYTES);
  localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  dmem_state_t           state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  logic [AW-1:0]         req_idx;
  logic                  out_of_range;
  logic                  misaligned;
  logic                  accept;
  dmem_req_class_t       req_class;
  logic                  arr_we;
  logic [AW-1:0]         arr_raddr;
  logic [DATA_WIDTH-1:0] arr_rdata;

  assign req_idx      = req_addr[AW+OW-1:OW];
  assign out_of_range = (req_addr >> OW) >= DATA_WIDTH'(DEPTH);
  assign accept       = req_valid && req_ready_q;

`ifdef DMEM_ALIGN_CHECK_EN
  assign misaligned = |req_addr[OW-1:0];
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    if ((req_read == req_write) || out_of_range || misaligned) req_class = REQ_ERR;
    else if (req_write)                                          req_class = REQ_WRITE;
    else                                                         req_class = REQ_READ;
  end

  // Reads index the incoming address at accept (latency 1) and the latched one afterwards.
  assign arr_we    = accept && (req_class == REQ_WRITE);
  assign arr_raddr = (state_q == DM_IDLE) ? req_idx : idx_q;

  dmem_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .waddr(req_idx),
    .wdata(req_wdata),
    .raddr(arr_raddr),
    .rdata(arr_rdata)
  );

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;

    unique case (state_q)
      DM_IDLE: begin
        if (accept) begin
          unique case (req_class)
            REQ_READ: begin
              idx_d = req_idx;
              if (READ_LATENCY == 1) begin
                state_d     = DM_RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = arr_rdata;
              end else begin
                state_d = DM_WAIT;
                cnt_d   = CW'(READ_LATENCY - 1);
              end
            end
            REQ_WRITE: begin
              state_d     = DM_RESP;
              rsp_valid_d = 1'b1;
              rsp_err_d   = 1'b0;
              rsp_rdata_d = '0;
            end
            default: begin
              state_d     = DM_RESP;
              rsp_valid_d = 1'b1;
              rsp_err_d   = 1'b1;
              rsp_rdata_d = '0;
            end
          endcase
        end
      end
      DM_WAIT: begin
        if (cnt_q <= CW'(1)) begin
          state_d     = DM_RESP;
          cnt_d       = '0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = arr_rdata;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DM_RESP: begin
        if (rsp_ready) begin
          state_d     = DM_IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
        end
      end
      default: state_d = DM_IDLE;
    endcase

    req_ready_d = (state_d == DM_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= DM_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed corner cases plus randomized
// transactions scored against a word-array model built from the request rules.
module tb_dmem_responder;

  localparam int DW    = 32;
  localparam int DEPTH = 256;
  localparam int LAT   = 2;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_read, req_write;
  logic [DW-1:0] req_addr, req_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] model_mem   [DEPTH];
  bit            model_known [DEPTH];

  dmem_responder #(
    .DATA_WIDTH  (DW),
    .DEPTH       (DEPTH),
    .READ_LATENCY(LAT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_read (req_read),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  always #5 clk = ~clk;

  function automatic bit exp_err(input bit rd, input bit wr, input logic [DW-1:0] addr);
    bit e;
    e = (rd == wr) || ((addr / 4) >= DEPTH);
    if (ALIGN_CHECK && (addr % 4) != 0) e = 1'b1;
    return e;
  endfunction

  // One full transaction: wait for ready, present the request for one edge, measure the
  // response latency, hold off the consumer for `hold` cycles, then complete the handshake.
  task automatic do_txn(input bit rd, input bit wr, input logic [DW-1:0] addr,
                        input logic [DW-1:0] wdata, input int hold, input string name);
    int            waited, lat, exp_lat, idx;
    bit            e, data_known;
    logic [DW-1:0] exp_data, held_data;
    logic          held_err;
    e          = exp_err(rd, wr, addr);
    idx        = int'(addr / 4) % DEPTH;
    data_known = 1'b1;
    exp_data   = '0;
    if (!e && rd) begin
      data_known = model_known[idx];
      exp_data   = model_mem[idx];
    end
    waited = 0;
    while (req_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s ready_timeout: req_ready=%b required 1", name, req_ready);
      return;
    end
    req_valid = 1'b1; req_read = rd; req_write = wr; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    if (!e && wr) begin
      model_mem[idx]   = wdata;
      model_known[idx] = 1'b1;
    end
    @(negedge clk);
    req_valid = 1'b0; req_read = $urandom; req_write = $urandom;
    req_addr = $urandom; req_wdata = $urandom;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    exp_lat = (e || wr) ? 1 : LAT;
    tests++;
    if (lat != exp_lat) begin
      fails++;
      $display("FAIL %s latency: got %0d cycles, required %0d", name, lat, exp_lat);
    end
    tests++;
    if (rsp_err !== e) begin
      fails++;
      $display("FAIL %s rsp_err: got %b, required %b", name, rsp_err, e);
    end
    if (data_known) begin
      tests++;
      if (rsp_rdata !== exp_data) begin
        fails++;
        $display("FAIL %s rsp_rdata: got %h, required %h", name, rsp_rdata, exp_data);
      end
    end
    held_data = rsp_rdata;
    held_err  = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      tests++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== held_data || rsp_err !== held_err || req_ready !== 1'b0) begin
        fails++;
        $display("FAIL %s stall_stable: valid=%b rdata=%h err=%b req_ready=%b, required 1 %h %b 0",
                 name, rsp_valid, rsp_rdata, rsp_err, req_ready, held_data, held_err);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s handshake: rsp_valid=%b req_ready=%b, required 0 1", name, rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== '0 || rsp_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: ready=%b valid=%b rdata=%h err=%b, required 0 0 0 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    rst_n = 1'b1;
    #1;
    tests++;
    if (req_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_release_ready: got %b before first edge, required 0", req_ready);
    end
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_first_edge_ready: got %b, required 1", req_ready);
    end
  endtask

  task automatic test_write_read;
    do_txn(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 0, "write_0x10");
    do_txn(1'b1, 1'b0, 32'h10, 32'h0, 0, "read_0x10");
    tests++;
    if (rsp_rdata !== 32'h0 && rsp_valid === 1'b0) begin
      fails++;
      $display("FAIL idle_rdata: got %h, required 0", rsp_rdata);
    end
  endtask

  task automatic test_errors;
    do_txn(1'b0, 1'b1, 32'h20, 32'h1234_5678, 0, "write_0x20");
    do_txn(1'b1, 1'b1, 32'h20, 32'hFFFF_0000, 0, "both_strobes_0x20");
    do_txn(1'b1, 1'b0, 32'h20, 32'h0, 0, "read_0x20_unchanged");
    do_txn(1'b1, 1'b0, 32'h400, 32'h0, 0, "read_out_of_range");
    do_txn(1'b0, 1'b1, 32'h400, 32'hCAFE_F00D, 0, "write_out_of_range");
    do_txn(1'b0, 1'b0, 32'h10, 32'h0, 0, "no_strobes");
    do_txn(1'b1, 1'b0, 32'h3FC, 32'h0, 0, "read_last_word");
  endtask

  task automatic test_alignment;
    do_txn(1'b1, 1'b0, 32'h11, 32'h0, 0, "read_0x11");
    do_txn(1'b0, 1'b1, 32'h13, 32'h0BAD_0BAD, 0, "write_0x13");
    do_txn(1'b1, 1'b0, 32'h10, 32'h0, 0, "read_0x10_after_0x13");
  endtask

  task automatic test_backpressure;
    do_txn(1'b1, 1'b0, 32'h20, 32'h0, 5, "read_stall5");
    do_txn(1'b0, 1'b1, 32'h24, 32'h5555_AAAA, 3, "write_stall3");
  endtask

  task automatic test_reset_mid;
    int idle_bad;
    wait (req_ready === 1'b1);
    @(negedge clk);
    req_valid = 1'b1; req_read = 1'b1; req_write = 1'b0; req_addr = 32'h10;
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_in_wait: valid=%b ready=%b, required 0 0", rsp_valid, req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle_bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) idle_bad++;
    end
    tests++;
    if (idle_bad != 0) begin
      fails++;
      $display("FAIL reset_wait_release: %0d bad cycles, required 0", idle_bad);
    end
    // Write accepted, then reset while its response is pending: data must stay committed.
    req_valid = 1'b1; req_read = 1'b0; req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'h0F0F_1234;
    @(posedge clk);
    model_mem[12] = 32'h0F0F_1234;
    model_known[12] = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    tests++;
    if (rsp_valid !== 1'b1) begin
      fails++;
      $display("FAIL write_before_reset_valid: got %b, required 1", rsp_valid);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_in_resp: valid=%b err=%b, required 0 0", rsp_valid, rsp_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_txn(1'b1, 1'b0, 32'h30, 32'h0, 0, "read_after_reset_commit");
  endtask

  task automatic test_back_to_back;
    int            accepts;
    logic [DW-1:0] last;
    accepts = 0;
    last = '0;
    wait (req_ready === 1'b1);
    @(negedge clk);
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_read = 1'b0; req_write = 1'b1; req_addr = 32'h40;
    for (int k = 0; k < 12; k++) begin
      req_wdata = 32'hA5A5_0000 | k;
      if (req_ready === 1'b1) begin
        accepts++;
        last = req_wdata;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    model_mem[16] = last;
    model_known[16] = 1'b1;
    tests++;
    if (accepts != 6) begin
      fails++;
      $display("FAIL back_to_back_accepts: got %0d in 12 cycles, required 6", accepts);
    end
    do_txn(1'b1, 1'b0, 32'h40, 32'h0, 0, "read_back_to_back_last");
    do_txn(1'b0, 1'b1, 32'h44, 32'h7777_1111, 0, "raw_write");
    do_txn(1'b1, 1'b0, 32'h44, 32'h0, 0, "raw_read");
  endtask

  task automatic test_random;
    bit            rd, wr;
    logic [DW-1:0] addr;
    int            pick;
    for (int n = 0; n < 80; n++) begin
      pick = $urandom_range(0, 15);
      rd   = (pick < 7) || (pick == 14);
      wr   = (pick >= 7 && pick < 13) || (pick == 14);
      if ($urandom_range(0, 9) == 0) addr = 32'h400 + ($urandom_range(0, 1023) * 4);
      else                           addr = $urandom_range(0, 15) * 4;
      if ($urandom_range(0, 5) == 0) addr = addr | $urandom_range(1, 3);
      do_txn(rd, wr, addr, $urandom, $urandom_range(0, 3), "random");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) model_known[i] = 1'b0;
    test_reset;
    test_write_read;
    test_errors;
    test_alignment;
    test_backpressure;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
